// File: rtl/roll_pkg.sv
// -----------------------------------------------------------------------------
// roll_pkg
// Shared types and helpers for the roll scheduler.
//   roll_state_t : FSM encoding for the scheduler (IDLE/START/ROLL/CAPTURE)
//   MIN_IDX_W    : smallest width used for any index/counter field
//   idx_width()  : width needed to hold values 0..n-1, never below MIN_IDX_W
// -----------------------------------------------------------------------------
package roll_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_ROLL    = 2'd2,
    S_CAPTURE = 2'd3
  } roll_state_t;

  // A zero-width field is illegal, so a single requester or a one-cycle roll
  // still gets a one-bit index/counter.
  localparam int MIN_IDX_W = 1;

  function automatic int idx_width(input int n);
    return (n <= 2) ? MIN_IDX_W : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick over the latched request bits. The search
// starts one position after the last served requester and wraps, so the most
// recently served requester has the lowest priority.
// Ports:
//   i_pending  [N_REQ-1:0] : latched requests
//   i_last     [ID_W-1:0]  : last served requester
//   o_grant_oh [N_REQ-1:0] : one-hot winner (all zero when nothing pending)
//   o_grant_id [ID_W-1:0]  : binary winner index
//   o_any                  : at least one request pending
// -----------------------------------------------------------------------------
module rr_arbiter
  import roll_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ID_W  = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [ID_W-1:0]  i_last,
  output logic [N_REQ-1:0] o_grant_oh,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_any
);

  logic w_found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise the tool infers a latch.
    o_grant_oh = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      int idx;
      idx = int'(i_last) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && i_pending[idx]) begin
        w_found         = 1'b1;
        o_grant_oh[idx] = 1'b1;
        o_grant_id      = ID_W'(idx);
      end
    end
  end

  assign o_any = |i_pending;

endmodule

// File: rtl/roll_scheduler.sv
// -----------------------------------------------------------------------------
// roll_scheduler
// Shares one random-number roller core among N_REQ debounced key requesters.
// Request pulses are latched, granted round-robin, and for each grant the core
// is started, left rolling for ROLL_CYCLES cycles, and its value captured into
// the requester's result slot.
// Ports:
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_req      [N_REQ]   : one-cycle request pulses, one per requester
//   i_core_value [VAL_W] : current roller output
//   o_start              : one-cycle start pulse to the roller
//   o_busy               : high while a grant is in START/ROLL/CAPTURE
//   o_grant_id           : requester being served (holds last ID when idle)
//   o_pending  [N_REQ]   : latched, not-yet-served requests
//   o_result   [N_REQ*VAL_W] : captured values, slot k at [k*VAL_W +: VAL_W]
//   o_result_valid [N_REQ]   : slot k holds a captured value
// -----------------------------------------------------------------------------
module roll_scheduler
  import roll_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int VAL_W       = 4,
  parameter int ROLL_CYCLES = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [VAL_W-1:0]           i_core_value,
  output logic                       o_start,
  output logic                       o_busy,
  output logic [$clog2(N_REQ)-1:0]   o_grant_id,
  output logic [N_REQ-1:0]           o_pending,
  output logic [N_REQ*VAL_W-1:0]     o_result,
  output logic [N_REQ-1:0]           o_result_valid
);

  localparam int ID_W  = idx_width(N_REQ);
  localparam int CNT_W = idx_width(ROLL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROLL_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

  roll_state_t              r_state;
  roll_state_t              w_state_nxt;
  logic [CNT_W-1:0]         r_cnt;
  logic [ID_W-1:0]          r_grant;
  logic [ID_W-1:0]          r_last;
  logic [N_REQ-1:0]         r_pending;
  logic [N_REQ*VAL_W-1:0]   r_result;
  logic [N_REQ-1:0]         r_valid;
  logic                     r_start;
  logic                     r_busy;

  logic [N_REQ-1:0]         w_arb_oh;
  logic [ID_W-1:0]          w_arb_id;
  logic                     w_arb_any;
  logic                     w_take;
  logic                     w_capture;
  logic                     w_start_d;
  logic                     w_busy_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick
  // ---------------------------------------------------------------------------
  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_pending  (r_pending),
    .i_last     (r_last),
    .o_grant_oh (w_arb_oh),
    .o_grant_id (w_arb_id),
    .o_any      (w_arb_any)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_arb_any) w_state_nxt = S_START;
      S_START:   w_state_nxt = S_ROLL;
      S_ROLL:    if (r_cnt == '0) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // o_start and o_busy are registered from the next state so the outputs come
  // straight from flops yet line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_take    = (r_state == S_IDLE) && w_arb_any;
    w_capture = (r_state == S_CAPTURE);
    w_start_d = (w_state_nxt == S_START);
    w_busy_d  = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_start <= w_start_d;
      r_busy  <= w_busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Roll counter: loaded on entry to ROLL, counts down to zero
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == S_ROLL && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending latch: a new pulse in the grant cycle wins over the clear, so a
  // requester that re-presses exactly then is not lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~(w_take ? w_arb_oh : '0)) | i_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Grant and last-grant pointers. Last-grant resets to N_REQ-1 so the first
  // search begins at requester 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grant <= '0;
      r_last  <= LAST_RST;
    end else begin
      if (w_take)    r_grant <= w_arb_id;
      if (w_capture) r_last  <= r_grant;
    end
  end

  // ---------------------------------------------------------------------------
  // Result slots
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: the result slots are reset, not left uninitialised, because they
    // drive the display decoders directly and must read 0 after reset.
    if (i_rst) begin
      r_result <= '0;
      r_valid  <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (r_grant == ID_W'(k)) begin
          r_result[k*VAL_W +: VAL_W] <= i_core_value;
          r_valid[k]                 <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_start        = r_start;
  assign o_busy         = r_busy;
  assign o_grant_id     = r_grant;
  assign o_pending      = r_pending;
  assign o_result       = r_result;
  assign o_result_valid = r_valid;

endmodule

// File: tb/tb_roll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_roll_scheduler
// Directed bench for roll_scheduler with N_REQ=3, VAL_W=4, ROLL_CYCLES=4.
// Cycle c means the interval after the c-th rising edge counted from the
// cycle in which the first request of a scenario is driven (cycle 0).
// -----------------------------------------------------------------------------
module tb_roll_scheduler;

  localparam int N_REQ       = 3;
  localparam int VAL_W       = 4;
  localparam int ROLL_CYCLES = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [VAL_W-1:0]       core;
  logic                   o_start;
  logic                   o_busy;
  logic [1:0]             o_grant_id;
  logic [N_REQ-1:0]       o_pending;
  logic [N_REQ*VAL_W-1:0] o_result;
  logic [N_REQ-1:0]       o_result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  roll_scheduler #(
    .N_REQ       (N_REQ),
    .VAL_W       (VAL_W),
    .ROLL_CYCLES (ROLL_CYCLES)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req          (req),
    .i_core_value   (core),
    .o_start        (o_start),
    .o_busy         (o_busy),
    .o_grant_id     (o_grant_id),
    .o_pending      (o_pending),
    .o_result       (o_result),
    .o_result_valid (o_result_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge, ready to drive cycle 0.
  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    core = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; core = '0;
    tick();
    n_checks++; if (o_start !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", o_start); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    n_checks++; if (o_grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant got=%0d exp=0", o_grant_id); end
    n_checks++; if (o_pending !== 3'b000) begin n_fail++; $display("FAIL reset_pending got=%b exp=000", o_pending); end
    n_checks++; if (o_result !== 12'h000) begin n_fail++; $display("FAIL reset_result got=%h exp=000", o_result); end
    n_checks++; if (o_result_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid got=%b exp=000", o_result_valid); end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++; if (o_start !== 1'b0 || o_busy !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle c=%0d start=%b busy=%b exp=0/0", c, o_start, o_busy);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    core = 4'hA;
    req  = 3'b001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      req = '0;
      n_checks++; if (o_start !== (c == 2)) begin n_fail++; $display("FAIL single_start c=%0d got=%b exp=%b", c, o_start, (c == 2)); end
      n_checks++; if (o_busy !== (c >= 2 && c <= 7)) begin n_fail++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, o_busy, (c >= 2 && c <= 7)); end
      if (c == 1) begin
        n_checks++; if (o_pending !== 3'b001) begin n_fail++; $display("FAIL single_pending c=1 got=%b exp=001", o_pending); end
      end
      if (c == 2) begin
        n_checks++; if (o_pending !== 3'b000 || o_grant_id !== 2'd0) begin
          n_fail++; $display("FAIL single_grant c=2 pending=%b grant=%0d exp=000/0", o_pending, o_grant_id);
        end
      end
      if (c == 7) begin
        n_checks++; if (o_result_valid !== 3'b000) begin n_fail++; $display("FAIL single_early_valid c=7 got=%b exp=000", o_result_valid); end
      end
      if (c >= 8) begin
        n_checks++; if (o_result[3:0] !== 4'hA || o_result_valid !== 3'b001) begin
          n_fail++; $display("FAIL single_result c=%0d res=%h valid=%b exp=a/001", c, o_result[3:0], o_result_valid);
        end
      end
    end
  endtask

  // Core value equals the cycle number, so captures at 7, 14, 21 give 7, E, 5.
  task automatic test_simultaneous();
    logic       prev_start;
    logic       exp_start;
    logic [1:0] exp_id;
    do_reset();
    req        = 3'b111;
    prev_start = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      tick();
      req  = '0;
      core = 4'(c);
      exp_start = (c == 2) || (c == 9) || (c == 16);
      exp_id    = (c == 2) ? 2'd0 : (c == 9) ? 2'd1 : 2'd2;
      n_checks++; if (o_start !== exp_start) begin n_fail++; $display("FAIL simul_start c=%0d got=%b exp=%b", c, o_start, exp_start); end
      if (exp_start) begin
        n_checks++; if (o_grant_id !== exp_id) begin n_fail++; $display("FAIL simul_grant c=%0d got=%0d exp=%0d", c, o_grant_id, exp_id); end
      end
      n_checks++; if (prev_start === 1'b1 && o_start === 1'b1) begin n_fail++; $display("FAIL back_to_back_start c=%0d got=1 exp=0", c); end
      prev_start = o_start;
      if (c == 21) begin
        n_checks++; if (o_result_valid !== 3'b011) begin n_fail++; $display("FAIL simul_valid21 got=%b exp=011", o_result_valid); end
      end
      if (c == 22) begin
        n_checks++; if (o_result_valid !== 3'b111) begin n_fail++; $display("FAIL simul_valid22 got=%b exp=111", o_result_valid); end
        n_checks++; if (o_result !== 12'h5E7) begin n_fail++; $display("FAIL simul_result got=%h exp=5e7", o_result); end
      end
    end
  endtask

  task automatic test_fairness_wrap();
    logic exp_start;
    do_reset();
    req = 3'b010;
    for (int c = 1; c <= 18; c++) begin
      tick();
      req = (c == 8) ? 3'b011 : 3'b000;
      exp_start = (c == 2) || (c == 10) || (c == 17);
      n_checks++; if (o_start !== exp_start) begin n_fail++; $display("FAIL wrap_start c=%0d got=%b exp=%b", c, o_start, exp_start); end
      if (c == 2) begin
        n_checks++; if (o_grant_id !== 2'd1) begin n_fail++; $display("FAIL wrap_first c=2 got=%0d exp=1", o_grant_id); end
      end
      if (c == 9) begin
        n_checks++; if (o_pending !== 3'b011) begin n_fail++; $display("FAIL wrap_pending c=9 got=%b exp=011", o_pending); end
      end
      if (c == 10) begin
        n_checks++; if (o_grant_id !== 2'd0 || o_pending !== 3'b010) begin
          n_fail++; $display("FAIL wrap_order c=10 grant=%0d pending=%b exp=0/010", o_grant_id, o_pending);
        end
      end
      if (c == 17) begin
        n_checks++; if (o_grant_id !== 2'd1) begin n_fail++; $display("FAIL wrap_second c=17 got=%0d exp=1", o_grant_id); end
      end
    end
  endtask

  task automatic test_rereq();
    logic exp_start;
    do_reset();
    core = 4'h3;
    req  = 3'b001;
    for (int c = 1; c <= 16; c++) begin
      tick();
      req  = (c == 4) ? 3'b001 : 3'b000;
      core = (c >= 9) ? 4'hC : 4'h3;
      exp_start = (c == 2) || (c == 9);
      n_checks++; if (o_start !== exp_start) begin n_fail++; $display("FAIL rereq_start c=%0d got=%b exp=%b", c, o_start, exp_start); end
      if (c == 3 || c == 9) begin
        n_checks++; if (o_pending !== 3'b000) begin n_fail++; $display("FAIL rereq_clear c=%0d got=%b exp=000", c, o_pending); end
      end
      if (c == 5) begin
        n_checks++; if (o_pending !== 3'b001) begin n_fail++; $display("FAIL rereq_pending c=5 got=%b exp=001", o_pending); end
      end
      if (c == 8) begin
        n_checks++; if (o_result[3:0] !== 4'h3) begin n_fail++; $display("FAIL rereq_first c=8 got=%h exp=3", o_result[3:0]); end
      end
      if (c == 15) begin
        n_checks++; if (o_result[3:0] !== 4'hC || o_result_valid !== 3'b001) begin
          n_fail++; $display("FAIL rereq_overwrite c=15 res=%h valid=%b exp=c/001", o_result[3:0], o_result_valid);
        end
      end
    end
  endtask

  // Requester 0 completes, then requester 1 is rolling with 2 pending when
  // reset hits; everything, including the earlier result, must clear.
  task automatic test_reset_mid_roll();
    do_reset();
    core = 4'h9;
    req  = 3'b001;
    for (int c = 1; c <= 12; c++) begin
      tick();
      req = (c == 8) ? 3'b110 : 3'b000;
      if (c == 8) begin
        n_checks++; if (o_result_valid !== 3'b001 || o_result !== 12'h009) begin
          n_fail++; $display("FAIL midroll_pre c=8 valid=%b res=%h exp=001/009", o_result_valid, o_result);
        end
      end
      if (c == 10) begin
        n_checks++; if (o_start !== 1'b1 || o_grant_id !== 2'd1 || o_pending !== 3'b100) begin
          n_fail++; $display("FAIL midroll_grant c=10 start=%b grant=%0d pending=%b exp=1/1/100", o_start, o_grant_id, o_pending);
        end
      end
      if (c == 12) begin
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL midroll_busy c=12 got=%b exp=1", o_busy); end
      end
    end
    rst = 1'b1;
    #1;
    n_checks++; if ({o_start, o_busy, o_grant_id} !== 4'b0000) begin
      n_fail++; $display("FAIL midroll_async_ctl start=%b busy=%b grant=%0d exp=0/0/0", o_start, o_busy, o_grant_id);
    end
    n_checks++; if (o_pending !== 3'b000 || o_result_valid !== 3'b000 || o_result !== 12'h000) begin
      n_fail++; $display("FAIL midroll_async_data pending=%b valid=%b res=%h exp=000/000/000", o_pending, o_result_valid, o_result);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      n_checks++; if (o_start !== 1'b0 || o_busy !== 1'b0 || o_pending !== 3'b000) begin
        n_fail++; $display("FAIL midroll_quiet c=%0d start=%b busy=%b pending=%b exp=0/0/000", c, o_start, o_busy, o_pending);
      end
    end
  endtask

  task automatic test_collision();
    logic exp_start;
    do_reset();
    req = 3'b010;
    for (int c = 1; c <= 12; c++) begin
      tick();
      req = (c == 1) ? 3'b010 : 3'b000;
      exp_start = (c == 2) || (c == 9);
      n_checks++; if (o_start !== exp_start) begin n_fail++; $display("FAIL collide_start c=%0d got=%b exp=%b", c, o_start, exp_start); end
      if (c == 1) begin
        n_checks++; if (o_pending !== 3'b010) begin n_fail++; $display("FAIL collide_pending1 got=%b exp=010", o_pending); end
      end
      if (c == 2) begin
        n_checks++; if (o_pending !== 3'b010 || o_grant_id !== 2'd1) begin
          n_fail++; $display("FAIL collide_setwins c=2 pending=%b grant=%0d exp=010/1", o_pending, o_grant_id);
        end
      end
      if (c == 8) begin
        n_checks++; if (o_result_valid !== 3'b010) begin n_fail++; $display("FAIL collide_valid c=8 got=%b exp=010", o_result_valid); end
      end
      if (c == 9) begin
        n_checks++; if (o_grant_id !== 2'd1) begin n_fail++; $display("FAIL collide_regrant c=9 got=%0d exp=1", o_grant_id); end
      end
      if (c == 10) begin
        n_checks++; if (o_pending !== 3'b000) begin n_fail++; $display("FAIL collide_drained c=10 got=%b exp=000", o_pending); end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    core = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness_wrap();
    test_rereq();
    test_reset_mid_roll();
    test_collision();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
